// File: rtl/execute_unit_if.sv
// Instruction issue and writeback bundle between the issue stage and execute_unit.
interface execute_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic        use_imm;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
    logic        illegal;

    modport master (
        output in_valid, opcode, rd, op_a, op_b, imm, use_imm,
        input  in_ready, wb_valid, wb_rd, wb_data, busy, illegal
    );

    modport slave (
        input  in_valid, opcode, rd, op_a, op_b, imm, use_imm,
        output in_ready, wb_valid, wb_rd, wb_data, busy, illegal
    );
endinterface

// File: rtl/execute_unit.sv
// Integer execute unit: single-cycle ALU ops, 32-cycle shift-add multiply and
// 32-cycle restoring divide, one writeback pulse per legal instruction.
module execute_unit (
    input  logic         clk,
    input  logic         reset,
    execute_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_t;

    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [3:0]  opc_q;
    logic [3:0]  rd_q;
    logic [31:0] a_q;       // multiplicand, or dividend shifting into quotient
    logic [31:0] b_q;       // multiplier, or divisor
    logic [31:0] acc_q;     // product accumulator, or partial remainder
    logic [3:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        illegal_q;

    logic        accept;
    logic [31:0] opnd_b;
    logic [31:0] mul_nxt;
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = $unsigned($signed(a) >>> b[4:0]);
            4'd8: r = {31'd0, $signed(a) < $signed(b)};
            4'd9: r = {31'd0, a < b};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign accept  = bus.in_valid && (state == S_IDLE || state == S_WB);
    assign opnd_b  = bus.use_imm ? bus.imm : bus.op_b;

    assign mul_nxt = acc_q + (b_q[0] ? a_q : 32'd0);

    // Remainder is always below the divisor, so the subtracted value fits in 32 bits.
    assign rem_sh  = {acc_q, a_q[31]};
    assign div_ge  = rem_sh >= {1'b0, b_q};
    assign rem_nxt = div_ge ? (rem_sh[31:0] - b_q) : rem_sh[31:0];
    assign quo_nxt = {a_q[30:0], div_ge};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_WB: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (bus.opcode == OP_MUL)                              state_nxt = S_MUL;
                    else if (bus.opcode == OP_DIVU || bus.opcode == OP_REMU) state_nxt = S_DIV;
                    else if (bus.opcode > OP_REMU)                          state_nxt = S_IDLE;
                    else                                                   state_nxt = S_WB;
                end
            end
            S_MUL, S_DIV: if (cnt == 5'd31) state_nxt = S_WB;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 5'd0;
            opc_q     <= 4'd0;
            rd_q      <= 4'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            acc_q     <= 32'd0;
            wb_rd_q   <= 4'd0;
            wb_data_q <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                S_MUL: begin
                    acc_q <= mul_nxt;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        wb_rd_q   <= rd_q;
                        wb_data_q <= mul_nxt;
                    end
                end
                S_DIV: begin
                    acc_q <= rem_nxt;
                    a_q   <= quo_nxt;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        wb_rd_q   <= rd_q;
                        wb_data_q <= (opc_q == OP_REMU) ? rem_nxt : quo_nxt;
                    end
                end
                default: begin
                    cnt <= 5'd0;
                    if (accept) begin
                        opc_q <= bus.opcode;
                        rd_q  <= bus.rd;
                        a_q   <= bus.op_a;
                        b_q   <= opnd_b;
                        acc_q <= 32'd0;
                        if (bus.opcode > OP_REMU) begin
                            illegal_q <= 1'b1;
                        end else if (bus.opcode < OP_MUL) begin
                            wb_rd_q   <= bus.rd;
                            wb_data_q <= alu(bus.opcode, bus.op_a, opnd_b);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready = (state == S_IDLE) || (state == S_WB);
    assign bus.busy     = (state == S_MUL) || (state == S_DIV);
    assign bus.wb_valid = (state == S_WB);
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.illegal  = illegal_q;
endmodule
